// File: rtl/mc_arm_controller.sv
// Multicycle control FSM for the single-ALU ARM subset datapath: sequences
// fetch/decode/execute, drives every mux select and strobe, and owns the Z flag.
module mc_arm_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Instr,
  input  logic        ALUFlags,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        FlagZ,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  state_t state_q, state_d;
  logic   z_q, z_d;

  logic [1:0] op;
  logic       imm_i, ld_l;
  logic [3:0] cmd, cond;
  logic       cond_ex, is_wr_cmd, is_cmp;
  logic [1:0] alu_cmd;
  logic       irw, pcw, rw, mw;
  logic       unused_instr;

  assign op    = Instr[27:26];
  assign imm_i = Instr[25];
  assign cmd   = Instr[24:21];
  assign ld_l  = Instr[20];
  assign cond  = Instr[31:28];
  assign unused_instr = ^Instr[19:0];

  assign ImmSrc = (op == 2'b11) ? 2'b00 : op;

  // Conditions are judged against the flag as it stood before this instruction.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z_q;
      4'b0001: cond_ex = ~z_q;
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    alu_cmd   = 2'b00;
    is_wr_cmd = 1'b0;
    is_cmp    = 1'b0;
    case (cmd)
      CMD_ADD: begin alu_cmd = 2'b00; is_wr_cmd = 1'b1; end
      CMD_SUB: begin alu_cmd = 2'b01; is_wr_cmd = 1'b1; end
      CMD_MOV: begin alu_cmd = 2'b10; is_wr_cmd = 1'b1; end
      CMD_CMP: begin alu_cmd = 2'b11; is_cmp    = 1'b1; end
      default: alu_cmd = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = S_FETCH;
    z_d        = z_q;
    ALUControl = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    irw        = 1'b0;
    pcw        = 1'b0;
    rw         = 1'b0;
    mw         = 1'b0;
    case (state_q)
      S_FETCH: begin
        irw = 1'b1; pcw = 1'b1;
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10;
        case (op)
          2'b00:   state_d = imm_i ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_cmd;
        if (is_cmp && cond_ex) z_d = ALUFlags;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw = cond_ex & is_wr_cmd;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = ld_l ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = cond_ex;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mw     = cond_ex;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10;
        pcw     = cond_ex;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked combinationally so they drop the instant reset asserts.
  assign IRWrite  = irw & reset_n;
  assign PCWrite  = pcw & reset_n;
  assign RegWrite = rw  & reset_n;
  assign MemWrite = mw  & reset_n;
  assign FlagZ    = z_q;
  assign State    = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
    end
  end

endmodule

// File: tb/tb_mc_arm_controller.sv
// Randomized and directed checks of the multicycle ARM controller against a
// per-instruction trace model derived from the instruction-class rules.
module tb_mc_arm_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic        ALUFlags = 1'b0;
  logic [1:0]  ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic        AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, FlagZ;
  logic [3:0]  State;

  mc_arm_controller dut (
    .clk(clk), .reset_n(reset_n), .Instr(Instr), .ALUFlags(ALUFlags),
    .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .FlagZ(FlagZ), .State(State)
  );

  always #5 clk = ~clk;

  // {State, ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc, IRWrite,
  //  PCWrite, RegWrite, MemWrite, FlagZ}
  logic [21:0] obs;
  assign obs = {State, ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
                IRWrite, PCWrite, RegWrite, MemWrite, FlagZ};

  int total = 0;
  int bad   = 0;
  logic zm = 1'b0;
  logic [21:0] exp_q[$];
  logic [21:0] got_q[$];

  function automatic logic [21:0] row(input logic [3:0] s, input logic [1:0] ac,
      input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
      input logic [1:0] im, input logic ad, input logic ir, input logic pc,
      input logic rw, input logic mw, input logic z);
    return {s, ac, sa, sb, rs, im, ad, ir, pc, rw, mw, z};
  endfunction

  // Builds the expected cycle-by-cycle trace of one instruction from its class.
  task automatic build_model(input logic [31:0] ins, input logic fl);
    logic [1:0] op, im, ac;
    logic       cx, wr, cmp;
    logic [3:0] cond, cmd;
    op = ins[27:26]; cond = ins[31:28]; cmd = ins[24:21];
    im = (op == 2'd3) ? 2'd0 : op;
    cx  = (cond == 4'd0) ? zm : (cond == 4'd1) ? !zm : (cond == 4'd14);
    wr  = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1101);
    cmp = (cmd == 4'b1010);
    ac  = (cmd == 4'b0010) ? 2'd1 : (cmd == 4'b1101) ? 2'd2 : cmp ? 2'd3 : 2'd0;
    exp_q.delete();
    exp_q.push_back(row(4'd0, 2'd0, 2'd1, 2'd2, 2'd2, im, 0, 1, 1, 0, 0, zm));
    exp_q.push_back(row(4'd1, 2'd0, 2'd1, 2'd2, 2'd0, im, 0, 0, 0, 0, 0, zm));
    if (op == 2'd0) begin
      exp_q.push_back(row(ins[25] ? 4'd7 : 4'd6, ac, 2'd0, ins[25] ? 2'd1 : 2'd0,
                          2'd0, im, 0, 0, 0, 0, 0, zm));
      if (cmp && cx) zm = fl;
      exp_q.push_back(row(4'd8, 2'd0, 2'd0, 2'd0, 2'd0, im, 0, 0, 0, cx & wr, 0, zm));
    end else if (op == 2'd1) begin
      exp_q.push_back(row(4'd2, 2'd0, 2'd0, 2'd1, 2'd0, im, 0, 0, 0, 0, 0, zm));
      if (ins[20]) begin
        exp_q.push_back(row(4'd3, 2'd0, 2'd0, 2'd0, 2'd0, im, 1, 0, 0, 0, 0, zm));
        exp_q.push_back(row(4'd4, 2'd0, 2'd0, 2'd0, 2'd1, im, 0, 0, 0, cx, 0, zm));
      end else
        exp_q.push_back(row(4'd5, 2'd0, 2'd0, 2'd0, 2'd0, im, 1, 0, 0, 0, cx, zm));
    end else if (op == 2'd2)
      exp_q.push_back(row(4'd9, 2'd0, 2'd2, 2'd1, 2'd2, im, 0, 0, cx, 0, 0, zm));
  endtask

  // Called just after a posedge with the DUT in FETCH; leaves it the same way.
  task automatic exec_instr(input logic [31:0] ins, input logic fl);
    build_model(ins, fl);
    got_q.delete();
    Instr = ins; ALUFlags = fl;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      got_q.push_back(obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    Instr = 32'hE2821005;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (obs !== row(4'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL reset_hold got=%h exp=%h", obs,
                      row(4'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0));
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    zm = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] prog[8] = '{32'hE2821005, 32'hE1510002, 32'h0A000002, 32'hE5910004,
                             32'hE5810004, 32'hE1510002, 32'h0A000002, 32'h02821005};
    logic        fls[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      exec_instr(prog[k], fls[k]);
      foreach (exp_q[i]) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL directed i%0d %h cyc%0d got=%h exp=%h",
                          k, prog[k], i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_cond_cmp;
    // Z is 0 here; CMPEQ must leave it alone even with the ALU reporting zero.
    logic [31:0] seq[3] = '{32'h01510002, 32'h11510002, 32'h01510002};
    for (int k = 0; k < 3; k++) begin
      exec_instr(seq[k], 1'b1);
      foreach (exp_q[i]) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL cond_cmp i%0d cyc%0d got=%h exp=%h",
                          k, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] conds[4] = '{4'h0, 4'h1, 4'hE, 4'h0};
    logic [3:0] cmds[5]  = '{4'b0100, 4'b0010, 4'b1101, 4'b1010, 4'h0};
    logic [31:0] ins;
    for (int k = 0; k < 300; k++) begin
      ins = $urandom;
      conds[3] = 4'($urandom);
      cmds[4]  = 4'($urandom);
      ins[31:28] = conds[$urandom_range(0, 3)];
      if (ins[27:26] == 2'd0) ins[24:21] = cmds[$urandom_range(0, 4)];
      exec_instr(ins, 1'($urandom));
      foreach (exp_q[i]) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL random i%0d %h cyc%0d got=%h exp=%h",
                          k, ins, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_memwr;
    exec_instr(32'hE1510002, 1'b1);
    Instr = 32'hE5810004;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if (State !== 4'd5 || MemWrite !== 1'b1 || FlagZ !== 1'b1) begin
      bad++; $display("FAIL memwr_before_rst got=%0d/%b/%b exp=5/1/1",
                      State, MemWrite, FlagZ);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (obs !== row(4'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL memwr_rst got=%h exp=%h", obs,
                      row(4'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 0, 0, 0, 0, 0, 0));
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    zm = 1'b0;
    exec_instr(32'hE2821005, 1'b0);
    foreach (exp_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL after_rst cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_cond_cmp;
    test_random;
    test_reset_mid_memwr;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_arm_controller.md
Name: mc_arm_controller

Overview:
- Multicycle control unit for the single-ALU ARM subset datapath. It is the driver side of the ALU interface: it issues the 2-bit ALU command and consumes the 1-bit zero flag.
- Sequences FETCH/DECODE/EXECUTE/memory/branch states and generates every datapath mux select and write strobe.
- Holds the architectural Z flag and evaluates condition codes for conditional execution.

Parameters:
- none (instruction subset and state encoding are fixed).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- Instr  in  32  held instruction register contents (valid from DECODE onward)
- ALUFlags  in  1  ALU zero flag; valid combinationally while the ALU command is 11
- ALUControl  out  2  00 add, 01 sub, 10 pass SrcB, 11 compare
- ALUSrcA  out  2  00 register Rn, 01 PC, 10 ALUOut
- ALUSrcB  out  2  00 register Rm, 01 extended immediate, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALUResult
- ImmSrc  out  2  00 8-bit data-processing, 01 12-bit memory, 10 24-bit branch
- AdrSrc  out  1  0 PC, 1 ALUOut
- IRWrite  out  1  instruction register load
- PCWrite  out  1  PC load
- RegWrite  out  1  register file write
- MemWrite  out  1  data memory write
- FlagZ  out  1  current architectural Z
- State  out  4  current FSM state (debug)

Behaviour:
Decode fields:
- op = Instr[27:26]; I = Instr[25]; cmd = Instr[24:21]; L = Instr[20]; cond = Instr[31:28].
- ImmSrc is combinational from op: 00→00, 01→01, 10→10, 11→00.
- Command map: ADD 0100→00, SUB 0010→01, MOV 1101→10, CMP 1010→11. Any other cmd drives 00 and is a NOP (no RegWrite, no flag update).

Condition evaluation:
- CondEx = (cond==0000 & Z) | (cond==0001 & ~Z) | (cond==1110). All other cond values give CondEx=0.
- CondEx always uses the registered Z, i.e. Z before the current instruction's update.

States and outputs (Moore; anything not listed is 0):
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1 → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ALUControl=00 (produces PC+8).
  - op=00, I=1 → EXECI
  - op=00, I=0 → EXECR
  - op=01 → MEMADR
  - op=10 → BRANCH
  - op=11 → FETCH (undefined instruction, no side effect)
- EXECR: ALUSrcA=00, ALUSrcB=00, ALUControl per command map → ALUWB.
- EXECI: ALUSrcA=00, ALUSrcB=01, ALUControl per command map → ALUWB.
  - Z update in EXECR/EXECI: Z is loaded from ALUFlags at the closing edge only if cmd==CMP and CondEx=1. Otherwise Z holds.
- ALUWB: ResultSrc=00, RegWrite = CondEx & (cmd ∈ {ADD, SUB, MOV}) → FETCH.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=00 → MEMRD if L=1, else MEMWR.
- MEMRD: AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx → FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondEx → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=CondEx → FETCH.

Latency:
- Data-processing: 4 cycles.
- LDR: 5 cycles.
- STR: 4 cycles.
- Branch: 3 cycles.
- Undefined op: 2 cycles.
- A failed condition costs the same number of cycles as an executed instruction.

Reset:
- reset_n low asynchronously forces State=FETCH and Z=0.
- While reset_n is low, IRWrite, PCWrite, RegWrite and MemWrite are gated to 0. Mux selects show FETCH values.
- The first FETCH strobes assert in the first cycle after reset_n is sampled high.
- Reset asserted mid-instruction abandons the instruction: no further strobes, and Z is cleared.

Other rules:
- At most one of RegWrite and MemWrite is high in any cycle.
- PCWrite is high only in FETCH and BRANCH.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9.

Test Plan:
- Reset released, Instr=0xE2821005 (ADD R1,R2,#5) → states 0,1,7,8; ALUControl=00 in EXECI; RegWrite=1 in ALUWB only; PCWrite=1 in FETCH only.
- 0xE1510002 (CMP R1,R2) with ALUFlags=1 in EXECR → ALUControl=11; Z=1 after EXECR; RegWrite=0 in ALUWB.
- With Z=1: 0x0A000002 (BEQ) → PCWrite=1 in BRANCH. With Z=0 → PCWrite=0 in BRANCH, and the block still returns to FETCH.
- 0xE5910004 (LDR) → states 0,1,2,3,4; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. 0xE5810004 (STR) → states 0,1,2,5; MemWrite=1 in MEMWR only.
- With Z=0: 0x02821005 (ADDEQ) → RegWrite=0 in ALUWB. CMP with cond=0000 while Z=0 → Z stays 0 regardless of ALUFlags.
- Assert reset_n low during MEMWR → MemWrite drops to 0 immediately, State=0, FlagZ=0; normal fetch resumes after release.
